vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Framebuffer access controller that shares one single-port synchronous pixel memory between VGA scan-out and a pixel writer (drawing engine). It prefetches scan-out pixels in bursts into an internal pixel FIFO that feeds the VGA driver's colour outputs. It grants writer cycles whenever the FIFO is not at risk of running dry. It sits between the framebuffer RAM, the writer, and the VGA timing/colour path.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines per frame.
- ADDR_W, 19: framebuffer word address width. Must hold H_ACTIVE*V_ACTIVE-1.
- DATA_W, 12: pixel width as {red[3:0], green[3:0], blue[3:0]}.
- BURST, 16: reads issued per prefetch burst.
- FIFO_DEPTH, 64: pixel FIFO entries. Power of two, ≥ 2*BURST.
- LOW_WATER, 16: urgent-refill threshold.
- RD_LAT, 2: memory read latency in cycles.

Ports:
- clk50MHz, in, 1: single clock. All logic is on its rising edge.
- reset, in, 1: synchronous, active-high.
- frame_start, in, 1: one-cycle pulse at the start of vertical blank.
- pix_pop, in, 1: consume the FIFO head pixel.
- pix_data, out, DATA_W: FIFO head pixel.
- pix_valid, out, 1: FIFO not empty.
- underflow, out, 1: sticky; set when pix_pop arrives while pix_valid=0.
- wr_valid, in, 1: writer request.
- wr_ready, out, 1: writer grant.
- wr_addr, in, ADDR_W: writer address.
- wr_data, in, DATA_W: writer pixel.
- mem_en, out, 1: memory access strobe (registered).
- mem_we, out, 1: 1 = write, 0 = read (registered).
- mem_addr, out, ADDR_W: memory address (registered).
- mem_wdata, out, DATA_W: memory write data (registered).
- mem_rdata, in, DATA_W: read data. Valid exactly RD_LAT cycles after a cycle with mem_en=1 and mem_we=0.

## Operation
- FSM states:
  - IDLE: decides the next memory operation each cycle.
  - RD_BURST: issues reads, one per cycle.
- Accounting and thresholds:
  - level = FIFO occupancy + reads in flight (issued, data not yet returned).
  - urgent = level < LOW_WATER.
  - room = level ≤ FIFO_DEPTH − BURST.
- Decision rules in IDLE, applied in this priority order:
  1. urgent and room and not frame_done → RD_BURST.
  2. wr_valid → grant the write. wr_ready is combinational: 1 in IDLE when the urgent-refill condition is false and frame_start=0.
  3. room and not frame_done → RD_BURST.
  4. Otherwise stay in IDLE.
- RD_BURST:
  - Issues exactly BURST reads at rd_addr, rd_addr+1, …, then returns to IDLE.
  - Writes are never granted while in RD_BURST.
- Read address (rd_addr):
  - Increments per issued read.
  - After address H_ACTIVE*V_ACTIVE−1 it wraps to 0 and frame_done sets. No further reads are issued until frame_start.
  - A burst that would cross the frame end is truncated at the last pixel.
- Read-return tracking: a RD_LAT-deep valid shift register pushes mem_rdata into the FIFO on its output.
- A write handshake (wr_valid & wr_ready) in cycle N drives mem_en=1, mem_we=1, wr_addr and wr_data in cycle N+1.
- frame_start effects (take priority over everything):
  - flush the FIFO;
  - clear the in-flight shift register, so pending returns are discarded;
  - abort RD_BURST → IDLE;
  - rd_addr=0; clear frame_done; clear underflow.
  - A write already registered onto the memory bus still completes.
- Simultaneous push and pop: occupancy is unchanged.
- A pop on an empty FIFO does not change occupancy; only underflow sets.

## Timing
- Reset values:
  - State IDLE, rd_addr=0, frame_done=0, FIFO empty.
  - pix_valid=0, pix_data=0, underflow=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. wr_ready=0 in the reset cycle.
- Reset asserted mid-burst or with reads in flight: all state is discarded, and returns arriving after reset are ignored.
- frame_start at cycle N:
  - FIFO empty and IDLE at N+1.
  - Read of address 0 at N+2; read of address BURST−1 at N+BURST+1.
  - First pix_valid at N+3+RD_LAT.
- Read-to-FIFO latency: 1 cycle after mem_rdata is valid.
- Pop-to-next-head latency: 0 cycles (first-word-fall-through FIFO).
- Memory bus: at most one access per cycle. A read burst occupies BURST consecutive cycles.
- Scan-out consumes one pixel every 2 cycles (25 MHz pixel rate). Sustained bandwidth therefore leaves ≥ 50% of cycles for writes.

## Structure
- Shared package vga_pkg:
  - H_ACTIVE, V_ACTIVE, FRAME_PIX, pixel-field slice constants;
  - FSM state enum {IDLE, RD_BURST}.
- Sub-module vga_pixel_fifo: synchronous first-word-fall-through FIFO with occupancy output and flush input.
- Top level holds the FSM, address counter, in-flight tracker and write path.

## Test plan
- Reset, then frame_start → mem_en reads at addresses 0..15 in consecutive cycles; pix_valid rises 5 cycles after frame_start (RD_LAT=2); pix_data matches the memory model.
- Steady pix_pop every 2nd cycle for a full frame with no writer → underflow stays 0; exactly 307200 reads issued; addresses wrap to 0 and reads stop until the next frame_start.
- Writer holds wr_valid=1 continuously during scan-out → writes are granted, level never falls below LOW_WATER−1, underflow=0, and every written word appears on the memory bus one cycle after its handshake.
- frame_start asserted mid-burst with 2 reads in flight → FIFO empties next cycle, the stale returns are not pushed, and the next read is at address 0.
- pix_pop with the FIFO empty → underflow=1 and holds until frame_start; occupancy stays 0.
- reset asserted during RD_BURST → all outputs return to reset values next cycle, and no FIFO push occurs from in-flight returns.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and types for the VGA framebuffer path
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;

  // Pixel word layout {red, green, blue}
  localparam int RED_HI = 11;
  localparam int RED_LO = 8;
  localparam int GRN_HI = 7;
  localparam int GRN_LO = 4;
  localparam int BLU_HI = 3;
  localparam int BLU_LO = 0;

  typedef enum logic {
    IDLE     = 1'b0,
    RD_BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vga_pixel_fifo.sv
// rtl/vga_pixel_fifo.sv - first-word-fall-through pixel FIFO with flush and occupancy
module vga_pixel_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 64
) (
  input  logic                       clk50MHz,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);
  import vga_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              do_push;
  logic              do_pop;

  // A pop on empty is ignored here; the caller flags it as underflow.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);

  assign valid = (count != '0);
  assign head  = valid ? store[rptr] : '0;

  always_ff @(posedge clk50MHz) begin
    if (do_push) begin
      store[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk50MHz) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - shares one framebuffer port between burst scan-out prefetch and a pixel writer
module vga_fb_arbiter #(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int BURST      = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LOW_WATER  = 16,
  parameter int RD_LAT     = 2
) (
  input  logic              clk50MHz,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underflow,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import vga_pkg::*;

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 2;
  localparam int BCNT_W = $clog2(BURST + 1);
  localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  arb_state_t        state;
  logic [ADDR_W-1:0] rd_addr;
  logic              frame_done;
  logic [BCNT_W-1:0] burst_left;
  logic [RD_LAT-1:0] rd_sr;

  logic [PTR_W:0]    fifo_count;
  logic [LVL_W-1:0]  inflight;
  logic [LVL_W-1:0]  level;
  logic              urgent;
  logic              room;
  logic              refill_urgent;
  logic              start_rd;
  logic              issue_rd;
  logic              do_wr;
  logic              rd_on_bus;

  assign rd_on_bus = mem_en && !mem_we;

  // Reads still on the bus or in the return pipe count toward the level,
  // so a burst is never started that the FIFO cannot absorb.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + LVL_W'(rd_sr[i]);
    end
    inflight = inflight + LVL_W'(rd_on_bus);
    level    = LVL_W'(fifo_count) + inflight;
  end

  assign urgent        = level < LVL_W'(LOW_WATER);
  assign room          = level <= LVL_W'(FIFO_DEPTH - BURST);
  assign refill_urgent = urgent && room && !frame_done;

  assign wr_ready = (state == IDLE) && !refill_urgent && !frame_start && !reset;
  assign do_wr    = wr_valid && wr_ready;
  assign start_rd = (state == IDLE) &&
                    (refill_urgent || (!wr_valid && room && !frame_done));
  assign issue_rd = start_rd || (state == RD_BURST);

  vga_pixel_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk50MHz  (clk50MHz),
    .reset     (reset),
    .flush     (frame_start),
    .push      (rd_sr[RD_LAT-1]),
    .push_data (mem_rdata),
    .pop       (pix_pop),
    .head      (pix_data),
    .valid     (pix_valid),
    .count     (fifo_count)
  );

  always_ff @(posedge clk50MHz) begin
    if (reset) begin
      state      <= IDLE;
      rd_addr    <= '0;
      frame_done <= 1'b0;
      burst_left <= '0;
      rd_sr      <= '0;
      underflow  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      rd_sr  <= RD_LAT'({rd_sr, rd_on_bus});
      if (pix_pop && !pix_valid) begin
        underflow <= 1'b1;
      end

      if (frame_start) begin
        // Returns still in the pipe belong to the old frame and are dropped.
        state      <= IDLE;
        rd_addr    <= '0;
        frame_done <= 1'b0;
        burst_left <= '0;
        underflow  <= 1'b0;
        rd_sr      <= '0;
      end else begin
        if (issue_rd) begin
          mem_en   <= 1'b1;
          mem_addr <= rd_addr;
          if (rd_addr == FRAME_LAST) begin
            rd_addr    <= '0;
            frame_done <= 1'b1;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end else if (do_wr) begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end

        // The IDLE cycle that starts a burst issues its first read itself.
        case (state)
          IDLE: begin
            if (start_rd) begin
              burst_left <= BCNT_W'(BURST - 1);
              if (rd_addr == FRAME_LAST || BURST == 1) begin
                state <= IDLE;
              end else begin
                state <= RD_BURST;
              end
            end
          end
          RD_BURST: begin
            burst_left <= burst_left - 1'b1;
            if (burst_left == BCNT_W'(1) || rd_addr == FRAME_LAST) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter on a 16x4 frame
module tb_vga_fb_arbiter;

  localparam int FRAME = 64;

  logic        clk50MHz = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        pix_pop;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic        underflow;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  int wcount = 0;
  logic [18:0] last_rd = '0;

  logic [11:0] s1, s2;

  always #5 clk50MHz = ~clk50MHz;

  vga_fb_arbiter #(
    .H_ACTIVE   (16),
    .V_ACTIVE   (4),
    .ADDR_W     (19),
    .DATA_W     (12),
    .BURST      (16),
    .FIFO_DEPTH (64),
    .LOW_WATER  (16),
    .RD_LAT     (2)
  ) dut (
    .clk50MHz    (clk50MHz),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_pop     (pix_pop),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underflow   (underflow),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  function automatic logic [11:0] pat(input int a);
    return 12'(a * 37 + 5);
  endfunction

  // Framebuffer content is a fixed pattern; read data appears two cycles after the request.
  always @(posedge clk50MHz) begin
    s1 <= pat(int'(mem_addr));
    s2 <= s1;
  end
  assign mem_rdata = s2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50MHz);
    #1;
    if (mem_en && !mem_we) begin
      rd_count++;
      last_rd = mem_addr;
    end
  endtask

  task automatic cyc(input logic pop, input int exp_idx);
    logic        hs;
    logic [18:0] a;
    logic [11:0] d;
    pix_pop = pop;
    if (pop) begin
      check_eq("pop_valid", pix_valid, 1);
      check_eq("pop_data", pix_data, pat(exp_idx));
    end
    hs = wr_valid && wr_ready;
    a  = wr_addr;
    d  = wr_data;
    tick();
    pix_pop = 1'b0;
    if (hs) begin
      wcount++;
      check_eq("wr_bus_cmd", {mem_en, mem_we}, 2'b11);
      check_eq("wr_bus_addr", mem_addr, a);
      check_eq("wr_bus_data", mem_wdata, d);
      wr_addr = wr_addr + 1'b1;
      wr_data = wr_data + 12'h035;
    end
  endtask

  task automatic fs_check();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    rd_count = 0;
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) tick();
      if (k == 1) begin
        check_eq("fs_mem_idle", mem_en, 0);
        check_eq("fs_underflow_clr", underflow, 0);
      end else begin
        check_eq("fs_rd_cmd", {mem_en, mem_we}, 2'b10);
        check_eq("fs_rd_addr", mem_addr, k - 2);
      end
      if (k < 5) begin
        check_eq("fs_pv_low", pix_valid, 0);
      end else if (k == 5) begin
        check_eq("fs_pv_high", pix_valid, 1);
        check_eq("fs_first_pix", pix_data, pat(0));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    pix_pop = 1'b0;
    wr_valid = 1'b1;
    wr_addr = 19'd200;
    wr_data = 12'h0a5;
    tick();
    tick();
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_pix_valid", pix_valid, 0);
    check_eq("rst_pix_data", pix_data, 0);
    check_eq("rst_underflow", underflow, 0);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0;
    wr_valid = 1'b0;

    // Full frame of scan-out, no writer
    fs_check();
    for (int i = 0; i < FRAME; i++) begin
      cyc(1'b1, i);
      cyc(1'b0, 0);
    end
    for (int i = 0; i < 20; i++) tick();
    check_eq("frame_reads", rd_count, FRAME);
    check_eq("frame_last_rd", last_rd, FRAME - 1);
    check_eq("frame_drained", pix_valid, 0);
    check_eq("frame_no_underflow", underflow, 0);

    // Pop on an empty FIFO
    pix_pop = 1'b1;
    tick();
    pix_pop = 1'b0;
    check_eq("uf_set", underflow, 1);
    check_eq("uf_empty", pix_valid, 0);
    for (int i = 0; i < 3; i++) tick();
    check_eq("uf_hold", underflow, 1);
    check_eq("uf_still_empty", pix_valid, 0);
    check_eq("uf_no_reads", rd_count, FRAME);

    // Continuous writer during scan-out
    fs_check();
    wr_valid = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      cyc(1'b1, i);
      cyc(1'b0, 0);
    end
    wr_valid = 1'b0;
    check_eq("wr_granted_enough", (wcount >= 64), 1);
    check_eq("wr_no_underflow", underflow, 0);

    // frame_start mid-burst with two reads in flight
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("mid_fifo_nonempty", pix_valid, 1);
    fs_check();

    // reset mid-burst
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pix_pop = 1'b1;
    tick();
    pix_pop = 1'b0;
    check_eq("rb_underflow_set", underflow, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rb_mem_en", mem_en, 0);
    check_eq("rb_mem_we", mem_we, 0);
    check_eq("rb_mem_addr", mem_addr, 0);
    check_eq("rb_mem_wdata", mem_wdata, 0);
    check_eq("rb_pix_valid", pix_valid, 0);
    check_eq("rb_pix_data", pix_data, 0);
    check_eq("rb_underflow", underflow, 0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (k == 2) begin
        check_eq("rb_rd_cmd", {mem_en, mem_we}, 2'b10);
        check_eq("rb_rd_addr", mem_addr, 0);
      end
      if (k < 5) begin
        check_eq("rb_no_stale", pix_valid, 0);
      end else begin
        check_eq("rb_pv_high", pix_valid, 1);
        check_eq("rb_first_pix", pix_data, pat(0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
